div32x32_seq: RTL and testbench

- Sequential unsigned integer divider: the inverse operation of the multiplier, and its companion in the arithmetic unit.
- Accepts a dividend and a divisor on a start handshake and runs one restoring-division step per clock, producing one quotient bit per cycle.
- Registers the quotient and remainder, then pulses done.
- Uses the same start/busy control convention as the multiplier control path, so one sequencer drives either unit.

---
 rtl/div32x32_seq_if.sv | 13 +
 rtl/div32x32_seq.sv | 83 ++++++++
 tb/tb_div32x32_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/div32x32_seq_if.sv
// div32x32_seq_if: start/busy handshake, operands and registered results of the divider
interface div32x32_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    modport master (output start, a, b, input busy, done, quotient, remainder, div_by_zero);
    modport slave (input start, a, b, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div32x32_seq.sv
// div32x32_seq: sequential unsigned restoring divider, one quotient bit per clock
module div32x32_seq #(parameter int WIDTH = 32) (
    input logic           clk,
    input logic           reset,
    div32x32_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] div_q, dvd_q, dvd_nxt, rem_q, rem_nxt, quo_q, rmd_q;
    logic [WIDTH:0]   tmp, diff;
    logic [CW-1:0]    cnt;
    logic             ge, dbz_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    // next state and Moore outputs; a zero divisor skips iteration entirely
    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = (bus.b != '0) ? CALC : DONE;
            CALC: begin
                bus.busy = 1'b1;
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // one restoring step; since rem_q < div_q always holds, the borrow bit alone decides tmp >= div_q
    always_comb begin
        tmp     = {rem_q, dvd_q[WIDTH-1]};
        diff    = tmp - {1'b0, div_q};
        ge      = ~diff[WIDTH];
        rem_nxt = ge ? diff[WIDTH-1:0] : tmp[WIDTH-1:0];
        dvd_nxt = {dvd_q[WIDTH-2:0], ge};
    end
    // working registers and results; results only change at completion
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            div_q <= '0;
            dvd_q <= '0;
            rem_q <= '0;
            cnt   <= '0;
            quo_q <= '0;
            rmd_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    div_q <= bus.b;
                    dvd_q <= bus.a;
                    rem_q <= '0;
                    cnt   <= CW'(WIDTH - 1);
                    if (bus.b == '0) begin
                        quo_q <= '1;
                        rmd_q <= bus.a;
                        dbz_q <= 1'b1;
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    dvd_q <= dvd_nxt;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        quo_q <= dvd_nxt;
                        rmd_q <= rem_nxt;
                        dbz_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_div32x32_seq.sv
// tb_div32x32_seq: directed vectors with a scoreboard queue checked on every done pulse
module tb_div32x32_seq;
    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t e;

    div32x32_seq_if #(.WIDTH(32)) bus();
    div32x32_seq #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // monitor: every done pulse must match the oldest expected result
    always @(negedge clk)
        if (reset && bus.done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 want no pending result at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("quotient", bus.quotient, e.q);
                chk("remainder", bus.remainder, e.r);
                chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.z});
            end
        end

    task automatic issue(input logic [31:0] av, bv, eq, er, input logic ez);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        sb.push_back('{eq, er, ez});
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // counts negedges until done; cycle 1 is the one right after the accepting edge
    task automatic wait_done(input int exp_lat, input int exp_busy);
        int   cyc = 0;
        int   nb = 0;
        logic seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) nb++;
            if (bus.done) seen = 1'b1;
        end
        chk("done_latency", cyc, exp_lat);
        chk("busy_cycles", nb, exp_busy);
    endtask

    task automatic op(input logic [31:0] av, bv, eq, er, input logic ez);
        issue(av, bv, eq, er, ez);
        wait_done(ez ? 1 : 33, ez ? 0 : 32);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #13;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_quotient", bus.quotient, 32'd0);
        chk("rst_remainder", bus.remainder, 32'd0);
        chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        op(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
        op(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
        op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
        op(32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
        op(32'hDEADBEEF, 32'hDEADBEEF, 32'd1, 32'd0, 1'b0);
        issue(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(28, 27);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd1000;
        bus.b     = 32'd10;
        sb.push_back('{32'd100, 32'd0, 1'b0});
        wait_done(33, 32);
        bus.a = 32'd21;
        bus.b = 32'd4;
        sb.push_back('{32'd5, 32'd1, 1'b0});
        wait_done(34, 32);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd1000;
        bus.b     = 32'd10;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_quotient", bus.quotient, 32'd0);
        chk("abort_remainder", bus.remainder, 32'd0);
        chk("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        op(32'd77, 32'd5, 32'd15, 32'd2, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
